// File: rtl/usb_transceiver.sv
// Low-speed USB PHY: bytes <-> NRZI bit-stuffed D+/D- line with SYNC and EOP framing.
// The receiver is always listening, so it also decodes the block's own transmission.
module usb_transceiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] d_i,
  output logic [1:0] d_o,
  output logic       d_en,
  output logic [1:0] line_state,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_active,
  output logic       rx_valid,
  output logic       rx_error,
  output logic [2:0] tx_fsm,
  output logic [1:0] rx_fsm
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [1:0] LVL_J   = 2'b01;
  localparam logic [1:0] LVL_K   = 2'b10;
  localparam logic [1:0] LVL_SE0 = 2'b00;

  // Handshake: tx_valid is a level request; tx_ready pulses in the cycle tx_data was
  // captured, so the next byte may be presented any time before the following byte end.
  // rx_valid/rx_error are single-cycle pulses, rx_data is stable until the next rx_valid.

  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_SYNC    = 3'd1,
    TX_DATA    = 3'd2,
    TX_EOP_SE0 = 3'd3,
    TX_EOP_J   = 3'd4
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_HUNT = 2'd0,
    RX_DATA = 2'd1,
    RX_EOP  = 2'd2,
    RX_WAIT = 2'd3
  } rx_state_t;

  function automatic logic [1:0] nrzi(input logic [1:0] cur, input logic b);
    if (b) return cur;
    return (cur == LVL_J) ? LVL_K : LVL_J;
  endfunction

  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [7:0]    tx_shift;
  logic [3:0]    tx_bits;
  logic [2:0]    tx_ones;
  logic          tx_bit_end;

  assign tx_bit_end = (tx_cnt == CW'(CLKS_PER_BIT - 1));
  assign tx_fsm     = tx_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      d_o      <= LVL_J;
      d_en     <= 1'b0;
      tx_ready <= 1'b0;
      tx_cnt   <= '0;
      tx_shift <= '0;
      tx_bits  <= '0;
      tx_ones  <= '0;
    end else begin
      tx_ready <= 1'b0;
      if (tx_state != TX_IDLE) tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
      case (tx_state)
        TX_IDLE: begin
          if (tx_valid) begin
            // First SYNC bit (a 0) is already on the wire here; 8'h80 >> 1 remains.
            tx_state <= TX_SYNC;
            d_en     <= 1'b1;
            d_o      <= LVL_K;
            tx_shift <= 8'h40;
            tx_bits  <= 4'd1;
            tx_ones  <= '0;
            tx_cnt   <= '0;
          end
        end
        TX_SYNC: begin
          if (tx_bit_end) begin
            if (tx_bits == 4'd8) begin
              tx_state <= TX_DATA;
              d_o      <= nrzi(d_o, tx_data[0]);
              tx_shift <= {1'b0, tx_data[7:1]};
              tx_bits  <= 4'd1;
              tx_ones  <= tx_data[0] ? tx_ones + 1'b1 : 3'd0;
              tx_ready <= 1'b1;
            end else begin
              d_o      <= nrzi(d_o, tx_shift[0]);
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bits  <= tx_bits + 1'b1;
              tx_ones  <= tx_shift[0] ? tx_ones + 1'b1 : 3'd0;
            end
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            if (tx_ones == 3'd6) begin
              // Stuffed 0 goes ahead of everything, including a byte boundary or EOP.
              d_o     <= nrzi(d_o, 1'b0);
              tx_ones <= '0;
            end else if (tx_bits == 4'd8) begin
              if (tx_valid) begin
                d_o      <= nrzi(d_o, tx_data[0]);
                tx_shift <= {1'b0, tx_data[7:1]};
                tx_bits  <= 4'd1;
                tx_ones  <= tx_data[0] ? tx_ones + 1'b1 : 3'd0;
                tx_ready <= 1'b1;
              end else begin
                tx_state <= TX_EOP_SE0;
                d_o      <= LVL_SE0;
                tx_bits  <= '0;
              end
            end else begin
              d_o      <= nrzi(d_o, tx_shift[0]);
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bits  <= tx_bits + 1'b1;
              tx_ones  <= tx_shift[0] ? tx_ones + 1'b1 : 3'd0;
            end
          end
        end
        TX_EOP_SE0: begin
          if (tx_bit_end) begin
            if (tx_bits == 4'd1) begin
              tx_state <= TX_EOP_J;
              d_o      <= LVL_J;
            end else begin
              tx_bits <= tx_bits + 1'b1;
            end
          end
        end
        TX_EOP_J: begin
          if (tx_bit_end) begin
            tx_state <= TX_IDLE;
            d_en     <= 1'b0;
            tx_bits  <= '0;
            tx_ones  <= '0;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  rx_state_t     rx_state;
  logic [1:0]    sync1;
  logic [1:0]    ls_prev;
  logic [1:0]    last_lvl;
  logic [CW-1:0] rx_cnt;
  logic [7:0]    rx_shift;
  logic [2:0]    rx_bits;
  logic [2:0]    rx_ones;
  logic [2:0]    zcnt;
  logic          trans;
  logic          sample;
  logic          lvl_se0;
  logic          rbit;

  assign rx_fsm = rx_state;

  // The bit clock re-phases on every line change and samples halfway into the bit.
  always_comb begin
    trans   = (line_state != ls_prev);
    sample  = !trans && (rx_cnt == CW'(CLKS_PER_BIT / 2));
    lvl_se0 = !((line_state == LVL_J) || (line_state == LVL_K));
    rbit    = (line_state == last_lvl);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= LVL_J;
      line_state <= LVL_J;
      ls_prev    <= LVL_J;
      last_lvl   <= LVL_J;
      rx_cnt     <= '0;
      rx_state   <= RX_HUNT;
      rx_active  <= 1'b0;
      rx_valid   <= 1'b0;
      rx_error   <= 1'b0;
      rx_data    <= '0;
      rx_shift   <= '0;
      rx_bits    <= '0;
      rx_ones    <= '0;
      zcnt       <= '0;
    end else begin
      sync1      <= d_i;
      line_state <= sync1;
      ls_prev    <= line_state;
      rx_valid   <= 1'b0;
      rx_error   <= 1'b0;
      rx_cnt     <= (trans || rx_cnt == CW'(CLKS_PER_BIT - 1)) ? '0 : rx_cnt + 1'b1;
      if (sample) begin
        last_lvl <= lvl_se0 ? LVL_J : line_state;
        case (rx_state)
          RX_HUNT: begin
            if (lvl_se0) begin
              zcnt <= '0;
            end else if (!rbit) begin
              zcnt <= (zcnt == 3'd7) ? zcnt : zcnt + 1'b1;
            end else begin
              zcnt <= '0;
              // A run of alternations closed by KK is the tail of SYNC.
              if (zcnt >= 3'd5 && line_state == LVL_K) begin
                rx_state  <= RX_DATA;
                rx_active <= 1'b1;
                rx_bits   <= '0;
                rx_ones   <= 3'd1;
              end
            end
          end
          RX_DATA: begin
            if (lvl_se0) begin
              if (rx_bits == 3'd0) begin
                rx_state <= RX_EOP;
              end else begin
                rx_error  <= 1'b1;
                rx_active <= 1'b0;
                rx_state  <= RX_WAIT;
              end
            end else if (rx_ones == 3'd6) begin
              if (rbit) begin
                rx_error  <= 1'b1;
                rx_active <= 1'b0;
                rx_state  <= RX_WAIT;
              end else begin
                rx_ones <= '0;
              end
            end else begin
              rx_shift <= {rbit, rx_shift[7:1]};
              rx_ones  <= rbit ? rx_ones + 1'b1 : 3'd0;
              rx_bits  <= rx_bits + 1'b1;
              if (rx_bits == 3'd7) begin
                rx_data  <= {rbit, rx_shift[7:1]};
                rx_valid <= 1'b1;
              end
            end
          end
          RX_EOP: begin
            if (line_state == LVL_J) begin
              rx_active <= 1'b0;
              rx_state  <= RX_HUNT;
              zcnt      <= '0;
            end else if (line_state == LVL_K) begin
              rx_error  <= 1'b1;
              rx_active <= 1'b0;
              rx_state  <= RX_WAIT;
            end
          end
          RX_WAIT: begin
            if (line_state == LVL_J) begin
              rx_state <= RX_HUNT;
              zcnt     <= '0;
            end
          end
          default: rx_state <= RX_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_transceiver.sv
// Directed bench for usb_transceiver: loopback packets plus externally driven faulty frames.
module tb_usb_transceiver;

  localparam logic [1:0] LVL_J   = 2'b01;
  localparam logic [1:0] LVL_K   = 2'b10;
  localparam logic [1:0] LVL_SE0 = 2'b00;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] d_i;
  logic [1:0] d_o;
  logic       d_en;
  logic [1:0] line_state;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_active;
  logic       rx_valid;
  logic       rx_error;
  logic [2:0] tx_fsm;
  logic [1:0] rx_fsm;

  logic       ext_en;
  logic [1:0] ext_d;

  int checks = 0;
  int failures = 0;
  int rx_cnt = 0;
  int err_cnt = 0;
  int err_run = 0;
  int max_err_w = 0;
  int both_cnt = 0;
  int rx_unexp = 0;
  int act_rises = 0;
  logic act_q = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] pkt[$];

  assign d_i = ext_en ? ext_d : (d_en ? d_o : LVL_J);

  usb_transceiver #(.CLKS_PER_BIT(16)) dut (
    .clk(clk), .reset(reset), .d_i(d_i), .d_o(d_o), .d_en(d_en),
    .line_state(line_state), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_active(rx_active),
    .rx_valid(rx_valid), .rx_error(rx_error), .tx_fsm(tx_fsm), .rx_fsm(rx_fsm)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Receive-side monitor and scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      act_q   = 1'b0;
      err_run = 0;
    end else begin
      if (rx_valid) begin
        rx_cnt++;
        if (exp_q.size() > 0) check_eq("rx_data", rx_data, exp_q.pop_front());
        else rx_unexp++;
      end
      if (rx_error) begin
        err_cnt++;
        err_run++;
      end else begin
        err_run = 0;
      end
      if (err_run > max_err_w) max_err_w = err_run;
      if (rx_valid && rx_error) both_cnt++;
      if (rx_active && !act_q) act_rises++;
      act_q = rx_active;
    end
  end

  task automatic run_packet(output int en_cyc, output int first_rdy, output logic [15:0] sync_w,
                            output int se0_c, output int jtail);
    int idx;
    int wait_c;
    bit se0_seen;
    idx = 0; wait_c = 0; se0_seen = 0;
    en_cyc = 0; first_rdy = -1; sync_w = '0; se0_c = 0; jtail = 0;
    tx_data  = pkt[0];
    tx_valid = 1'b1;
    while (!d_en && wait_c < 64) begin
      @(negedge clk);
      wait_c++;
    end
    check_eq("den_rise", d_en, 1);
    while (d_en && en_cyc < 40000) begin
      if (tx_ready) begin
        exp_q.push_back(tx_data);
        if (first_rdy < 0) first_rdy = en_cyc;
        idx++;
        if (idx < pkt.size()) tx_data = pkt[idx];
        else tx_valid = 1'b0;
      end
      if (en_cyc < 128 && en_cyc % 16 == 8) sync_w = {sync_w[13:0], d_o};
      if (d_o == LVL_SE0) begin
        se0_c++;
        se0_seen = 1;
      end else if (se0_seen && d_o == LVL_J) begin
        jtail++;
      end
      @(negedge clk);
      en_cyc++;
    end
    tx_valid = 1'b0;
    check_eq("den_fall", d_en, 0);
  endtask

  task automatic drive_level(input logic [1:0] lvl, input int bits);
    ext_d = lvl;
    repeat (16 * bits) @(negedge clk);
  endtask

  task automatic drive_sync_head();
    for (int i = 0; i < 6; i++) drive_level((i % 2 == 0) ? LVL_K : LVL_J, 1);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int en_cyc, first_rdy, se0_c, jtail;
    logic [15:0] sync_w;
    int r0, e0, a0;

    reset = 1'b1; tx_valid = 1'b0; tx_data = '0; ext_en = 1'b0; ext_d = LVL_J;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // Test 1: reset values
    check_eq("rst_d_en", d_en, 0);
    check_eq("rst_d_o", d_o, LVL_J);
    check_eq("rst_tx_ready", tx_ready, 0);
    check_eq("rst_rx_active", rx_active, 0);
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_rx_error", rx_error, 0);
    check_eq("rst_rx_data", rx_data, 0);
    check_eq("rst_fsms", {tx_fsm, rx_fsm}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("line_state_j", line_state, LVL_J);
    repeat (20) @(negedge clk);

    // Test 2: single byte C3 in loopback
    r0 = rx_cnt; e0 = err_cnt; a0 = act_rises;
    pkt = '{8'hC3};
    run_packet(en_cyc, first_rdy, sync_w, se0_c, jtail);
    repeat (40) @(negedge clk);
    check_eq("c3_sync_wire", sync_w, 16'h999A);
    check_eq("c3_first_ready", first_rdy, 128);
    check_eq("c3_en_cycles", en_cyc, 304);
    check_eq("c3_rx_count", rx_cnt - r0, 1);
    check_eq("c3_act_rise", act_rises - a0, 1);
    check_eq("c3_no_error", err_cnt - e0, 0);

    // Test 3: 100-byte stream
    r0 = rx_cnt; e0 = err_cnt;
    pkt.delete();
    for (int i = 0; i < 100; i++) pkt.push_back(8'($urandom_range(0, 255)));
    run_packet(en_cyc, first_rdy, sync_w, se0_c, jtail);
    check_eq("strm_rx_active_end", rx_active, 0);
    repeat (40) @(negedge clk);
    check_eq("strm_first_ready", first_rdy, 128);
    check_eq("strm_se0_cycles", se0_c, 32);
    check_eq("strm_j_tail", jtail, 16);
    check_eq("strm_rx_count", rx_cnt - r0, 100);
    check_eq("strm_pending", exp_q.size(), 0);
    check_eq("strm_no_error", err_cnt - e0, 0);

    // Test 4: FF,FF with stuffing across the byte boundary
    r0 = rx_cnt; e0 = err_cnt;
    pkt = '{8'hFF, 8'hFF};
    run_packet(en_cyc, first_rdy, sync_w, se0_c, jtail);
    repeat (40) @(negedge clk);
    check_eq("ff_en_cycles", en_cyc, 464);
    check_eq("ff_rx_count", rx_cnt - r0, 2);
    check_eq("ff_pending", exp_q.size(), 0);
    check_eq("ff_no_error", err_cnt - e0, 0);

    // Test 5: stuff error after SYNC
    r0 = rx_cnt; e0 = err_cnt; a0 = act_rises;
    ext_en = 1'b1;
    drive_level(LVL_J, 2);
    drive_sync_head();
    drive_level(LVL_K, 9);
    drive_level(LVL_J, 4);
    check_eq("stf_act_rise", act_rises - a0, 1);
    check_eq("stf_err_count", err_cnt - e0, 1);
    check_eq("stf_no_valid", rx_cnt - r0, 0);
    check_eq("stf_rx_active", rx_active, 0);

    // Test 6: partial byte before SE0
    r0 = rx_cnt; e0 = err_cnt; a0 = act_rises;
    drive_sync_head();
    drive_level(LVL_K, 2);
    drive_level(LVL_J, 2);
    drive_level(LVL_K, 1);
    drive_level(LVL_SE0, 2);
    drive_level(LVL_J, 4);
    ext_en = 1'b0;
    check_eq("part_act_rise", act_rises - a0, 1);
    check_eq("part_err_count", err_cnt - e0, 1);
    check_eq("part_no_valid", rx_cnt - r0, 0);
    check_eq("part_rx_active", rx_active, 0);

    check_eq("err_pulse_width", max_err_w, 1);
    check_eq("valid_error_overlap", both_cnt, 0);
    check_eq("rx_unexpected", rx_unexp, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_transceiver.md
Name: usb_transceiver

Overview:
Low-speed (1.5 Mbit/s) USB PHY-level transceiver sitting between the USB pins (D+/D-) and the SIE.
- TX path: serializes bytes LSB first, adds SYNC, bit-stuffs, NRZI-encodes and appends EOP.
- RX path: synchronizes the line, recovers the bit clock by oversampling, NRZI-decodes, unstuffs, detects SYNC/EOP and delivers bytes.
- RX is always active, so in loopback the receiver decodes the block's own transmission.

Parameters:
CLKS_PER_BIT, 16, system clocks per USB bit (24 MHz / 1.5 MHz).

Ports:
clk  in  1  system clock, 24 MHz; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
d_i  in  d_port_t (2: d_p,d_n)  USB D+/D- sampled from pins, asynchronous.
d_o  out  d_port_t  USB D+/D- drive value.
d_en  out  1  output enable for d_o; pins tri-stated when low.
line_state  out  d_port_t  d_i after 2-flop synchronizer.
tx_data  in  8  byte to transmit.
tx_valid  in  1  rise: start packet (SYNC); high: keep sending bytes; fall: EOP after current byte.
tx_ready  out  1  one-cycle pulse: tx_data was loaded; next byte may be presented.
rx_data  out  8  received byte, valid with rx_valid.
rx_active  out  1  high from SYNC detection to end of EOP or error.
rx_valid  out  1  one-cycle pulse per received byte.
rx_error  out  1  one-cycle pulse on receive error.

Behaviour:
Line encoding (low speed):
- J = {d_p,d_n} = 2'b01 (idle); K = 2'b10; SE0 = 2'b00.
- NRZI: data 0 toggles J/K; data 1 holds the level.

Reset:
- d_en=0, d_o=J, tx_ready=0, rx_active=0, rx_valid=0, rx_error=0, rx_data=0.
- line_state = J after the synchronizer flushes.
- TX and RX FSMs go to IDLE; stuff counters and bit counters cleared.

TX FSM (IDLE, SYNC, DATA, EOP_SE0, EOP_J):
- IDLE: on the first cycle tx_valid=1, the next cycle sets d_en=1 and starts SYNC.
- Every bit lasts exactly CLKS_PER_BIT cycles.
- SYNC: sends 8'b1000_0000 LSB first on the wire, i.e. K J K J K J K K.
- At the end of SYNC, tx_data is loaded into the shift register and tx_ready pulses for 1 cycle in that load cycle.
- DATA: 8 bits LSB first.
  - After six consecutive 1s, one stuffed 0 (a transition) is inserted.
  - The stuff count runs across byte boundaries; SYNC's final 1 counts toward it.
- At each byte end:
  - tx_valid=1: load tx_data, pulse tx_ready, continue with no gap.
  - Otherwise go to EOP.
- A stuff bit pending after the 6th 1 of the last byte is sent before EOP.
- EOP: 2 bit times SE0, then 1 bit time J, then d_en=0 and IDLE.
- tx_valid falling mid-byte: the byte completes normally.
- Reset mid-packet: aborts immediately, d_en=0.

RX:
- Synchronizer: 2 flops. Bit clock: a counter reset on every J/K transition; the bit is sampled at mid-bit (count CLKS_PER_BIT/2).
- Hunting for SYNC: sampled levels are decoded via NRZI. rx_active rises the cycle after a sample completes the pattern …0,1 preceded by at least 3 alternating KJ pairs, i.e. the final KK of SYNC.
- Data: bits shifted in LSB first.
  - After six consecutive 1s, the next bit must be 0 and is dropped.
  - Every 8 data bits: rx_data updated and rx_valid pulses 1 cycle.
- SE0 sampled: enters EOP.
  - Bit count aligned to a byte: the next J sample ends the packet and rx_active falls.
  - Partial byte pending: rx_error pulses and rx_active falls.
- Stuff error (seventh consecutive 1 sampled): rx_error pulses 1 cycle, rx_active=0, and the receiver waits for SE0/J idle before hunting again.
- rx_valid and rx_error are never high in the same cycle.
- Own transmission is received: no RX gating on d_en.

Test Plan:
1. Reset held 3 cycles → all outputs at reset values; with pins pulled to J, line_state=2'b01 within 2 cycles after release.
2. Loopback (d_i=d_o when d_en else J); tx_valid=1 with tx_data=8'hC3 → wire shows KJKJKJKK; first tx_ready 128 cycles after start; rx_active rises; rx_valid with rx_data=8'hC3.
3. Stream 100 random bytes, each updated on tx_ready, then drop tx_valid → received byte sequence equals transmitted; SE0 lasts 32 cycles, then J for 16 cycles, then d_en=0 and rx_active=0; rx_error never asserts.
4. Transmit 8'hFF,8'hFF → a stuffed transition after every 6 ones (including across the byte boundary); receiver returns FF,FF with no error.
5. Drive d_i externally: SYNC, then 7 bit times of no transition → rx_error pulse of 1 cycle, rx_active falls, and no rx_valid for that byte.
6. Drive SYNC, 3 data bits, then SE0 → rx_error pulse, and no rx_valid.
